if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined ARM (LEGv8) CPU. Owns the 64-bit program counter and presents it to the combinational instruction memory. Captures the returned 32-bit instruction into the IF/ID pipeline register for the decode stage. Handles decode/execute stalls, branch redirects with squash, a HALT state on a programmed halt encoding, and a fetched-instruction performance counter.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSN, 32'hD503201F, bubble encoding driven on ifid_instr when the slot is invalid.
- HALT_INSN, 32'hD4400000, encoding that moves the stage into HALT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID; from the hazard unit.
- redirect  in  1  branch or jump taken; load branch_target.
- branch_target  in  64  redirect destination.
- instr_in  in  32  instruction returned by instruction memory for pc_out, same cycle.
- pc_out  out  64  current PC, registered, to instruction memory.
- ifid_pc  out  64  PC of the instruction in IF/ID.
- ifid_instr  out  32  instruction in IF/ID; NOP_INSN when invalid.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  stage is in HALT.
- fetch_count  out  32  count of instructions latched valid, saturating.

## Operation
- State machine with two states: RUN and HALT. Reset enters RUN.
- Reset values: pc_out=RESET_PC, ifid_pc=0, ifid_instr=NOP_INSN, ifid_valid=0, halted=0, fetch_count=0. rst overrides every other input, in any state and mid-stall.
- RUN, per edge, in priority order:
  - redirect=1: pc_out<=branch_target with bits [1:0] forced to 0. IF/ID squashed (ifid_valid<=0, ifid_instr<=NOP_INSN, ifid_pc<=0). Count unchanged. Redirect beats stall.
  - stall=1: pc_out, IF/ID and fetch_count all hold.
  - instr_in==HALT_INSN: IF/ID<={pc_out, instr_in, valid=1}. Count increments. pc_out holds. Next state HALT.
  - otherwise: IF/ID<={pc_out, instr_in, 1}. pc_out<=pc_out+4, modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0. Count increments.
- HALT:
  - pc_out holds.
  - IF/ID becomes a bubble (valid=0, NOP_INSN) on the first HALT edge and stays so.
  - redirect and stall are ignored. Only rst leaves HALT.
- halted is 1 exactly while the state is HALT.
- fetch_count saturates at 32'hFFFF_FFFF and never wraps.
- The PC adder is 64-bit unsigned with the carry discarded. Alignment is not checked on the sequential path.

## Timing
- One-cycle fetch latency. pc_out is valid from the edge that loads it. Instruction memory returns instr_in combinationally, with its delay below the clock period. IF/ID captures instr_in at the next edge.
- After rst deasserts, the first edge latches {RESET_PC, IM[RESET_PC]} with ifid_valid=1. pc_out becomes RESET_PC+4 on that same edge.
- Redirect: the target appears on pc_out one edge after redirect is sampled. Its instruction reaches IF/ID one edge later, giving a one-cycle bubble.
- Stall is level-sensitive: each stalled cycle freezes one edge. There is no skid buffer. instr_in is re-read after the stall releases.
- Halt: the HALT_INSN slot is visible in IF/ID for exactly one cycle. halted rises on that same edge.

## Test plan
- Reset and sequential fetch: RESET_PC=0, IM[0..3]=8b1f03e5, f84000a4, 8b040086, f80010a6, no stall/redirect. Required: ifid_pc 0,4,8,12 on successive edges with matching instructions, ifid_valid=1 throughout, fetch_count=4.
- Stall: assert stall for 2 cycles while IF/ID holds PC 4. Required: pc_out stays 8, ifid_pc stays 4 for both cycles, count frozen. Fetch then resumes with PC 8.
- Redirect and squash: redirect with branch_target=64'h103 while stall=1. Required: next edge pc_out=64'h100, ifid_valid=0, ifid_instr=D503201F. The edge after that latches PC 100 with valid=1.
- Halt: IM[8]=D4400000. Required: ifid_instr=D4400000 with valid=1 for one cycle and halted=1. Subsequent cycles show a bubble and pc_out=8. A redirect is ignored. rst then returns to PC 0 in RUN.
- PC wrap: redirect to 64'hFFFF_FFFF_FFFF_FFFC, then a free run. Required: pc_out becomes 0 one edge after that PC is fetched.
- Counter saturation: force fetch_count to FFFF_FFFE and run 3 fetches. Required: the count reaches FFFF_FFFF and holds.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: LEGv8 fetch stage with 64-bit PC, IF/ID register, stall/redirect/halt handling and a saturating fetch counter.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INSN = 32'hD503201F,
  parameter logic [31:0] HALT_INSN = 32'hD4400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] branch_target,
  input  logic [31:0] instr_in,
  output logic [63:0] pc_out,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  logic fetch;
  assign fetch = state == RUN && !redirect && !stall;
  assign halted = state == HALT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc_out <= RESET_PC;
      ifid_pc <= '0;
      ifid_instr <= NOP_INSN;
      ifid_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      fetch_count <= fetch && fetch_count != '1 ? fetch_count + 32'd1 : fetch_count;
      if (state == HALT || redirect) begin
        ifid_pc <= '0;
        ifid_instr <= NOP_INSN;
        ifid_valid <= 1'b0;
        if (state == RUN) pc_out <= {branch_target[63:2], 2'b00};
      end else if (!stall) begin
        ifid_pc <= pc_out;
        ifid_instr <= instr_in;
        ifid_valid <= 1'b1;
        if (instr_in == HALT_INSN) state <= HALT;
        else pc_out <= pc_out + 64'd4;
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage against a behavioural fetch model.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'hD503201F;
  localparam logic [31:0] HLT = 32'hD4400000;
  typedef struct {
    logic [63:0] pc, ipc;
    logic [31:0] ins, cnt;
    logic v, h;
  } exp_t;
  logic clk = 0, rst = 1, stall = 0, redirect = 0;
  logic [63:0] branch_target = 0, pc_out, ifid_pc;
  logic [31:0] instr_in, ifid_instr, fetch_count;
  logic ifid_valid, halted;
  logic [31:0] mem [64];
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_ins, m_cnt;
  logic m_v, m_h;
  always #5 clk = ~clk;
  assign instr_in = mem[pc_out[7:2]];
  if_stage dut (.clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .branch_target(branch_target),
    .instr_in(instr_in), .pc_out(pc_out), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid), .halted(halted), .fetch_count(fetch_count));
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic rd, input logic [63:0] t);
    logic [31:0] i;
    rst = r; stall = s; redirect = rd; branch_target = t;
    if (r) begin
      m_pc = 0; m_ipc = 0; m_ins = NOP; m_v = 0; m_h = 0; m_cnt = 0;
    end else if (m_h) begin
      m_ipc = 0; m_ins = NOP; m_v = 0;
    end else if (rd) begin
      m_pc = t & ~64'd3; m_ipc = 0; m_ins = NOP; m_v = 0;
    end else if (!s) begin
      i = mem[m_pc[7:2]];
      m_ipc = m_pc; m_ins = i; m_v = 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (i == HLT) m_h = 1;
      else m_pc = m_pc + 4;
    end
    q.push_back('{pc: m_pc, ipc: m_ipc, ins: m_ins, cnt: m_cnt, v: m_v, h: m_h});
    @(negedge clk);
  endtask
  task automatic fill();
    for (int k = 0; k < 64; k++) begin
      mem[k] = $urandom;
      if (mem[k] == HLT) mem[k] = 0;
    end
    mem[0] = 32'h8b1f03e5; mem[1] = 32'hf84000a4; mem[2] = 32'h8b040086; mem[3] = 32'hf80010a6;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("ifid_pc", ifid_pc, e.ipc);
        chk("ifid_instr", {32'd0, ifid_instr}, {32'd0, e.ins});
        chk("ifid_valid", {63'd0, ifid_valid}, {63'd0, e.v});
        chk("halted", {63'd0, halted}, {63'd0, e.h});
        chk("fetch_count", {32'd0, fetch_count}, {32'd0, e.cnt});
      end
    end
  end
  initial begin
    fill();
    @(negedge clk);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 64'h103); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    mem[2] = HLT;
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 64'h40); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    mem[2] = 32'h8b040086;
    cyc(0, 0, 0, 0); cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0);
    force dut.fetch_count = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    cyc(0, 1, 0, 0);
    release dut.fetch_count;
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        cyc(1, 0, 0, 0);
        fill();
        if ($urandom_range(0, 1) == 1) mem[$urandom_range(1, 63)] = HLT;
      end else
        cyc(0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, {$urandom, $urandom});
    end
    @(posedge clk); @(posedge clk); #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
